// File: rtl/exc_pkg.sv
// exc_pkg: FSM state encoding, src_sel encodings and the vector address helper for exc_addr_seq
package exc_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_VEC = 2'd1, S_LOAD = 2'd2} state_t;
  localparam logic [1:0] SRC_PC  = 2'b00;
  localparam logic [1:0] SRC_ALU = 2'b01;
  function automatic logic [31:0] vec_addr(input int top, input int num, input int idx);
    return 32'(top - (num - 1) + idx);
  endfunction
endpackage

// File: rtl/exc_prio_enc.sv
// exc_prio_enc: highest-index priority encoder
//   i_req   in  N   request vector, bit N-1 has top priority
//   o_valid out 1   any request set
//   o_idx   out CW  index of the highest set request (0 when none)
module exc_prio_enc #(
  parameter int N  = 3,
  parameter int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  output logic          o_valid,
  output logic [CW-1:0] o_idx
);
  assign o_valid = |i_req;
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < N; i++) if (i_req[i]) o_idx = CW'(i);
  end
endmodule

// File: rtl/exc_addr_seq.sv
// exc_addr_seq: exception vector fetch sequencer (optional exc_mask port under EXC_ADDR_SEQ_MASK_EN)
//   clk, reset_n (sync, active-low); src_sel/in_pc/in_alu_out select the normal address;
//   exc_req per-cause requests; mem_rdata byte read at addr_out;
//   addr_out, exc_busy, epc, cause, pc_load strobe, pc_new handler address.
module exc_addr_seq
  import exc_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_EXC = 3,
  parameter int VEC_TOP = 255,
  parameter int MEM_LAT = 1,
  localparam int CW     = (NUM_EXC > 1) ? $clog2(NUM_EXC) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         src_sel,
  input  logic [WIDTH-1:0]   in_pc,
  input  logic [WIDTH-1:0]   in_alu_out,
  input  logic [NUM_EXC-1:0] exc_req,
`ifdef EXC_ADDR_SEQ_MASK_EN
  input  logic [NUM_EXC-1:0] exc_mask,
`endif
  input  logic [7:0]         mem_rdata,
  output logic [WIDTH-1:0]   addr_out,
  output logic               exc_busy,
  output logic [WIDTH-1:0]   epc,
  output logic [CW-1:0]      cause,
  output logic               pc_load,
  output logic [WIDTH-1:0]   pc_new
);
  state_t             r_state, w_next;
  logic [NUM_EXC-1:0] r_pend, w_en, w_req, w_cand, w_clr;
  logic [2:0]         r_cnt;
  logic [CW-1:0]      r_cause, w_idx;
  logic [WIDTH-1:0]   r_epc, r_pc_new, w_vec;
  logic               w_valid, w_acc, w_last;
`ifdef EXC_ADDR_SEQ_MASK_EN
  assign w_en = ~exc_mask;
`else
  assign w_en = '1;
`endif
  assign w_req  = exc_req & w_en;
  // masked pending bits are kept but not offered to the encoder
  assign w_cand = (r_pend | exc_req) & w_en;
  exc_prio_enc #(.N(NUM_EXC), .CW(CW)) u_enc (
    .i_req  (w_cand),
    .o_valid(w_valid),
    .o_idx  (w_idx)
  );
  assign w_acc  = (r_state == S_IDLE) && w_valid;
  assign w_last = r_cnt == 3'(MEM_LAT - 1);
  assign w_clr  = w_acc ? NUM_EXC'(1) << w_idx : '0;
  assign w_vec  = WIDTH'(vec_addr(VEC_TOP, NUM_EXC, int'(r_cause)));
  always_ff @(posedge clk)
    r_state <= !reset_n ? S_IDLE : w_next;
  always_comb begin
    w_next   = r_state;
    w_next   = r_state == S_IDLE ? (w_valid ? S_VEC : S_IDLE) :
               r_state == S_VEC  ? (w_last ? S_LOAD : S_VEC) : S_IDLE;
    exc_busy = r_state != S_IDLE;
    // reset_n gating keeps a reset in LOAD from completing the handoff
    pc_load  = (r_state == S_LOAD) && reset_n;
    addr_out = r_state != S_IDLE ? w_vec : src_sel == SRC_ALU ? in_alu_out : in_pc;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pend   <= '0;
      r_cnt    <= '0;
      r_cause  <= '0;
      r_epc    <= '0;
      r_pc_new <= '0;
    end else begin
      r_pend <= (r_pend | w_req) & ~w_clr;
      r_cnt  <= w_acc ? '0 : (r_state == S_VEC && !w_last) ? r_cnt + 3'd1 : r_cnt;
      if (w_acc) begin
        r_cause <= w_idx;
        r_epc   <= in_pc - WIDTH'(4);
      end
      if (r_state == S_VEC && w_last) r_pc_new <= WIDTH'(mem_rdata);
    end
  end
  assign epc    = r_epc;
  assign cause  = r_cause;
  assign pc_new = r_pc_new;
endmodule

// File: tb/tb_exc_addr_seq.sv
// tb_exc_addr_seq: vector-table and scoreboard bench for exc_addr_seq (MEM_LAT=1 and MEM_LAT=3 instances)
module tb_exc_addr_seq;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  src_sel;
  logic [31:0] in_pc, in_alu_out;
  logic [2:0]  exc_req;
  logic [7:0]  mem_rdata;
  logic [31:0] addr_out, epc, pc_new, addr3, epc3, pc_new3;
  logic [1:0]  cause, cause3;
  logic        exc_busy, pc_load, busy3, load3;
  int          n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  exc_addr_seq #(.MEM_LAT(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .src_sel(src_sel), .in_pc(in_pc), .in_alu_out(in_alu_out),
    .exc_req(exc_req), .mem_rdata(mem_rdata), .addr_out(addr_out), .exc_busy(exc_busy),
    .epc(epc), .cause(cause), .pc_load(pc_load), .pc_new(pc_new)
  );
  exc_addr_seq #(.MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .src_sel(src_sel), .in_pc(in_pc), .in_alu_out(in_alu_out),
    .exc_req(exc_req), .mem_rdata(mem_rdata), .addr_out(addr3), .exc_busy(busy3),
    .epc(epc3), .cause(cause3), .pc_load(load3), .pc_new(pc_new3)
  );
  typedef struct {
    logic        rst_n;
    logic [1:0]  sel;
    logic [31:0] pc;
    logic [2:0]  req;
    logic [7:0]  rd;
    logic [31:0] e_addr;
    logic        e_busy;
    logic        e_load;
    logic        chk;
    logic [31:0] e_epc;
    logic [1:0]  e_cause;
    logic [31:0] e_new;
  } vec_t;
  vec_t tbl[$];
  vec_t sb[$];
  function automatic vec_t mk(logic r, logic [1:0] s, logic [31:0] p, logic [2:0] q, logic [7:0] d,
                              logic [31:0] a, logic b, logic l, logic c, logic [31:0] e,
                              logic [1:0] ca, logic [31:0] n);
    vec_t v;
    v = '{r, s, p, q, d, a, b, l, c, e, ca, n};
    return v;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic r, input logic [1:0] s, input logic [31:0] p, input logic [2:0] q,
                       input logic [7:0] d);
    @(posedge clk);
    #1;
    reset_n = r; src_sel = s; in_pc = p; exc_req = q; mem_rdata = d;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec_t v;
    reset_n = 1'b0; src_sel = 2'b01; in_pc = 32'h100; in_alu_out = 32'h40; exc_req = '0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    tbl.push_back(mk(0, 2'b01, 32'h100, 3'b000, 8'h00, 32'h40,  0, 0, 1, 32'h0,   2'd0, 32'h0));
    tbl.push_back(mk(1, 2'b01, 32'h100, 3'b000, 8'h00, 32'h40,  0, 0, 0, 32'h0,   2'd0, 32'h0));
    tbl.push_back(mk(1, 2'b00, 32'h100, 3'b000, 8'h00, 32'h100, 0, 0, 0, 32'h0,   2'd0, 32'h0));
    tbl.push_back(mk(1, 2'b10, 32'h200, 3'b000, 8'h00, 32'h200, 0, 0, 0, 32'h0,   2'd0, 32'h0));
    tbl.push_back(mk(1, 2'b11, 32'h100, 3'b010, 8'h00, 32'h100, 0, 0, 0, 32'h0,   2'd0, 32'h0));
    tbl.push_back(mk(1, 2'b01, 32'h100, 3'b000, 8'h8c, 32'hfe,  1, 0, 1, 32'hfc,  2'd1, 32'h0));
    tbl.push_back(mk(1, 2'b01, 32'h100, 3'b000, 8'h00, 32'hfe,  1, 1, 1, 32'hfc,  2'd1, 32'h8c));
    tbl.push_back(mk(1, 2'b01, 32'h100, 3'b000, 8'h00, 32'h40,  0, 0, 1, 32'hfc,  2'd1, 32'h8c));
    tbl.push_back(mk(1, 2'b01, 32'h300, 3'b101, 8'h00, 32'h40,  0, 0, 0, 32'h0,   2'd0, 32'h0));
    tbl.push_back(mk(1, 2'b01, 32'h300, 3'b000, 8'h11, 32'hff,  1, 0, 1, 32'h2fc, 2'd2, 32'h8c));
    tbl.push_back(mk(1, 2'b01, 32'h300, 3'b000, 8'h00, 32'hff,  1, 1, 1, 32'h2fc, 2'd2, 32'h11));
    tbl.push_back(mk(1, 2'b01, 32'h400, 3'b000, 8'h00, 32'h40,  0, 0, 0, 32'h0,   2'd0, 32'h0));
    tbl.push_back(mk(1, 2'b01, 32'h400, 3'b000, 8'h22, 32'hfd,  1, 0, 1, 32'h3fc, 2'd0, 32'h11));
    tbl.push_back(mk(1, 2'b01, 32'h400, 3'b000, 8'h00, 32'hfd,  1, 1, 1, 32'h3fc, 2'd0, 32'h22));
    tbl.push_back(mk(1, 2'b01, 32'h400, 3'b000, 8'h00, 32'h40,  0, 0, 0, 32'h0,   2'd0, 32'h0));
    tbl.push_back(mk(1, 2'b01, 32'h500, 3'b100, 8'h00, 32'h40,  0, 0, 0, 32'h0,   2'd0, 32'h0));
    tbl.push_back(mk(1, 2'b01, 32'h500, 3'b001, 8'h33, 32'hff,  1, 0, 1, 32'h4fc, 2'd2, 32'h22));
    tbl.push_back(mk(1, 2'b01, 32'h500, 3'b000, 8'h00, 32'hff,  1, 1, 1, 32'h4fc, 2'd2, 32'h33));
    tbl.push_back(mk(1, 2'b01, 32'h600, 3'b000, 8'h00, 32'h40,  0, 0, 0, 32'h0,   2'd0, 32'h0));
    tbl.push_back(mk(1, 2'b01, 32'h600, 3'b000, 8'h44, 32'hfd,  1, 0, 1, 32'h5fc, 2'd0, 32'h33));
    tbl.push_back(mk(1, 2'b01, 32'h600, 3'b000, 8'h00, 32'hfd,  1, 1, 1, 32'h5fc, 2'd0, 32'h44));
    tbl.push_back(mk(1, 2'b01, 32'h600, 3'b000, 8'h00, 32'h40,  0, 0, 0, 32'h0,   2'd0, 32'h0));
    tbl.push_back(mk(1, 2'b01, 32'h700, 3'b010, 8'h00, 32'h40,  0, 0, 0, 32'h0,   2'd0, 32'h0));
    tbl.push_back(mk(1, 2'b01, 32'h700, 3'b010, 8'h55, 32'hfe,  1, 0, 1, 32'h6fc, 2'd1, 32'h44));
    tbl.push_back(mk(1, 2'b01, 32'h700, 3'b000, 8'h00, 32'hfe,  1, 1, 1, 32'h6fc, 2'd1, 32'h55));
    tbl.push_back(mk(1, 2'b01, 32'h800, 3'b000, 8'h00, 32'h40,  0, 0, 0, 32'h0,   2'd0, 32'h0));
    tbl.push_back(mk(1, 2'b01, 32'h800, 3'b000, 8'h66, 32'hfe,  1, 0, 1, 32'h7fc, 2'd1, 32'h55));
    tbl.push_back(mk(1, 2'b01, 32'h800, 3'b000, 8'h00, 32'hfe,  1, 1, 1, 32'h7fc, 2'd1, 32'h66));
    tbl.push_back(mk(1, 2'b01, 32'h800, 3'b000, 8'h00, 32'h40,  0, 0, 0, 32'h0,   2'd0, 32'h0));
    tbl.push_back(mk(1, 2'b01, 32'h900, 3'b100, 8'h00, 32'h40,  0, 0, 0, 32'h0,   2'd0, 32'h0));
    tbl.push_back(mk(0, 2'b01, 32'h900, 3'b001, 8'h99, 32'hff,  1, 0, 1, 32'h8fc, 2'd2, 32'h66));
    tbl.push_back(mk(1, 2'b01, 32'h900, 3'b000, 8'h00, 32'h40,  0, 0, 1, 32'h0,   2'd0, 32'h0));
    tbl.push_back(mk(1, 2'b01, 32'h900, 3'b000, 8'h00, 32'h40,  0, 0, 1, 32'h0,   2'd0, 32'h0));
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst_n, tbl[i].sel, tbl[i].pc, tbl[i].req, tbl[i].rd);
      sb.push_back(tbl[i]);
      @(negedge clk);
      v = sb.pop_front();
      chk($sformatf("v%0d addr_out", i), addr_out, v.e_addr);
      chk($sformatf("v%0d exc_busy", i), 32'(exc_busy), 32'(v.e_busy));
      chk($sformatf("v%0d pc_load", i), 32'(pc_load), 32'(v.e_load));
      if (v.chk) begin
        chk($sformatf("v%0d epc", i), epc, v.e_epc);
        chk($sformatf("v%0d cause", i), 32'(cause), 32'(v.e_cause));
        chk($sformatf("v%0d pc_new", i), pc_new, v.e_new);
      end
    end
    drive(0, 2'b01, 32'h100, 3'b000, 8'h00);
    drive(1, 2'b01, 32'h100, 3'b000, 8'h00);
    @(negedge clk);
    chk("lat3 idle addr", addr3, 32'h40);
    chk("lat3 idle busy", 32'(busy3), 32'd0);
    drive(1, 2'b01, 32'h100, 3'b010, 8'h00);
    @(negedge clk);
    chk("lat3 accept-cycle addr", addr3, 32'h40);
    for (int k = 1; k <= 4; k++) begin
      drive(1, 2'b01, 32'h100, 3'b000, k == 3 ? 8'h77 : 8'h00);
      @(negedge clk);
      chk($sformatf("lat3 t+%0d addr", k), addr3, 32'hfe);
      chk($sformatf("lat3 t+%0d busy", k), 32'(busy3), 32'd1);
      chk($sformatf("lat3 t+%0d pc_load", k), 32'(load3), 32'(k == 4));
    end
    drive(1, 2'b01, 32'h100, 3'b000, 8'h00);
    @(negedge clk);
    chk("lat3 return addr", addr3, 32'h40);
    chk("lat3 return pc_load", 32'(load3), 32'd0);
    chk("lat3 pc_new", pc_new3, 32'h77);
    chk("lat3 epc", epc3, 32'hfc);
    chk("lat3 cause", 32'(cause3), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
